// File: rtl/fetch_unit_if.sv
// Port bundle for fetch_unit: fetch control, imem request/response channel and
// the decoder valid/ready channel. master = fetch unit side, slave = environment side.
interface fetch_unit_if #(
  parameter int unsigned AWIDTH = 16
) ();
  logic              run;
  logic              redirect;
  logic [AWIDTH-1:0] redirect_pc;
  logic              imem_req;
  logic [AWIDTH-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_out;
  logic [AWIDTH-1:0] instr_pc;

  modport master (
    input  run, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc
  );

  modport slave (
    output run, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem reads, in-order instruction FIFO.
// Build option FETCH_NOP_FILL_EN: instr_out shows the NOP encoding while the FIFO is empty.
module fetch_unit #(
  parameter int unsigned       AWIDTH   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [SW-1:0] CREDITS = SW'(DEPTH);
`ifdef FETCH_NOP_FILL_EN
  localparam logic [31:0] EMPTY_WORD = 32'h0007_8000;
`else
  localparam logic [31:0] EMPTY_WORD = 32'h0000_0000;
`endif

  // state   | meaning
  // S_IDLE  | after reset, or redirected while stopped with nothing in flight
  // S_FETCH | issuing reads while run=1 and credits remain; buffering responses
  // S_FLUSH | discarding responses of reads issued before a redirect
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]     outst_q, outst_d, count_q, count_d;
  logic [PW-1:0]     tag_ptr_q, tag_ptr_d, dat_ptr_q, dat_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0] tag_mem_q [DEPTH];
  logic [31:0]       dat_mem_q [DEPTH];
  logic [SW-1:0]     used;
  logic              gnt, rsp, push, pop;

  // Slots are allocated at grant, so outstanding + buffered never exceeds DEPTH.
  assign used            = {1'b0, outst_q} + {1'b0, count_q};
  assign bus.imem_req    = (state_q == S_FETCH) && bus.run && (used < CREDITS);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr_out   = bus.instr_valid ? dat_mem_q[rd_ptr_q] : EMPTY_WORD;
  assign bus.instr_pc    = bus.instr_valid ? tag_mem_q[rd_ptr_q] : '0;

  assign gnt  = bus.imem_req & bus.imem_gnt;
  assign rsp  = bus.imem_rvalid & (outst_q != '0);
  assign push = rsp & (state_q == S_FETCH) & ~bus.redirect;
  assign pop  = bus.instr_valid & bus.instr_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    outst_d   = outst_q;
    count_d   = count_q;
    tag_ptr_d = tag_ptr_q;
    dat_ptr_d = dat_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (bus.redirect) begin
      pc_d      = bus.redirect_pc;
      outst_d   = outst_q + CW'(gnt) - CW'(rsp);
      count_d   = '0;
      tag_ptr_d = '0;
      dat_ptr_d = '0;
      rd_ptr_d  = '0;
      if (outst_d != '0)  state_d = S_FLUSH;
      else if (bus.run)   state_d = S_FETCH;
      else                state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.run) state_d = S_FETCH;
        S_FETCH: begin
          outst_d = outst_q + CW'(gnt) - CW'(rsp);
          count_d = count_q + CW'(push) - CW'(pop);
          if (gnt) begin
            pc_d      = pc_q + AWIDTH'(1);
            tag_ptr_d = tag_ptr_q + PW'(1);
          end
          if (push) dat_ptr_d = dat_ptr_q + PW'(1);
          if (pop)  rd_ptr_d  = rd_ptr_q + PW'(1);
        end
        S_FLUSH: begin
          outst_d = outst_q - CW'(rsp);
          if (outst_d == '0) state_d = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      count_q   <= '0;
      tag_ptr_q <= '0;
      dat_ptr_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      count_q   <= count_d;
      tag_ptr_q <= tag_ptr_d;
      dat_ptr_q <= dat_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt && !bus.redirect) tag_mem_q[tag_ptr_q] <= pc_q;
    if (push)                 dat_mem_q[dat_ptr_q] <= bus.imem_rdata;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases plus a random phase, checked every cycle
// against a queue-level model of the fetch stream, with literal spot checks.
module tb_fetch_unit;
  localparam int DEPTH = 4;
`ifdef FETCH_NOP_FILL_EN
  localparam logic [31:0] FILL = 32'h0007_8000;
`else
  localparam logic [31:0] FILL = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.AWIDTH(16)) bif ();
  fetch_unit #(.AWIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory environment: in-order responses, rdata = 0x100 + address.
  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];
  int    cyc = 0;
  int    gnt_mode = 1;
  int    lat_fix = 1;

  initial begin
    bif.imem_gnt = 1'b0;
    bif.imem_rvalid = 1'b0;
    bif.imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (gnt_mode)
        0:       bif.imem_gnt = 1'b0;
        1:       bif.imem_gnt = 1'b1;
        default: bif.imem_gnt = 1'($urandom_range(0, 1));
      endcase
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        bif.imem_rvalid = 1'b1;
        bif.imem_rdata  = 32'h100 + {16'h0, mem_q[0].addr};
      end else begin
        bif.imem_rvalid = 1'b0;
        bif.imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Reference model: PC, reads in flight (with how many are stale), delivered-word queue.
  logic [15:0] m_pc;
  logic [15:0] m_pend[$];
  logic [15:0] m_fifo[$];
  int          m_stale;
  bit          m_idle;
  bit          m_ok = 1'b0;

  function automatic bit exp_req();
    return !m_idle && (m_stale == 0) && bif.run && ((m_pend.size() + m_fifo.size()) < DEPTH);
  endfunction

  always @(negedge clk) begin : cmp
    bit          er;
    bit          g;
    logic [15:0] a;
    int          lat;
    if (m_ok) begin
      er = exp_req();
      chk("imem_req", 64'(bif.imem_req), 64'(er));
      chk("imem_addr", 64'(bif.imem_addr), 64'(m_pc));
      chk("instr_valid", 64'(bif.instr_valid), 64'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
        chk("instr_pc", 64'(bif.instr_pc), 64'(m_fifo[0]));
        chk("instr_out", 64'(bif.instr_out), 64'(32'h100 + {16'h0, m_fifo[0]}));
      end else begin
        chk("instr_out_empty", 64'(bif.instr_out), 64'(FILL));
      end
      chk("outstanding_le_depth", 64'(mem_q.size() <= DEPTH), 64'(1));
    end
    if (rst) begin
      mem_q.delete();
      m_pend.delete();
      m_fifo.delete();
      m_pc    = 16'h0000;
      m_stale = 0;
      m_idle  = 1'b1;
      m_ok    = 1'b1;
    end else begin
      if (bif.imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (bif.imem_req && bif.imem_gnt) begin
        lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
        mem_q.push_back('{addr: bif.imem_addr, due: cyc + lat});
      end
      g = exp_req() && bif.imem_gnt;
      if (bif.redirect) begin
        if (bif.imem_rvalid && m_pend.size() > 0) void'(m_pend.pop_front());
        if (g) m_pend.push_back(m_pc);
        m_stale = m_pend.size();
        m_fifo.delete();
        m_pc   = bif.redirect_pc;
        m_idle = (m_pend.size() == 0) && !bif.run;
      end else begin
        if (m_fifo.size() > 0 && bif.instr_ready) void'(m_fifo.pop_front());
        if (bif.imem_rvalid && m_pend.size() > 0) begin
          a = m_pend.pop_front();
          if (m_stale > 0) m_stale--;
          else             m_fifo.push_back(a);
        end
        if (g) begin
          m_pend.push_back(m_pc);
          m_pc = m_pc + 16'h1;
        end
        if (m_idle && bif.run) m_idle = 1'b0;
      end
    end
  end

  initial begin
    int  grants;
    bit  found;
    rst = 1'b1;
    bif.run = 1'b0;
    bif.redirect = 1'b0;
    bif.redirect_pc = 16'h0;
    bif.instr_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_imem_req", 64'(bif.imem_req), 64'(0));
    chk("rst_imem_addr", 64'(bif.imem_addr), 64'(16'h0000));
    chk("rst_instr_valid", 64'(bif.instr_valid), 64'(0));
    chk("rst_instr_out", 64'(bif.instr_out), 64'(FILL));
    chk("rst_instr_pc", 64'(bif.instr_pc), 64'(16'h0000));

    // Streaming with 1-cycle memory: first word two cycles after the first grant.
    tick(); bif.run = 1'b1;
    @(negedge clk); chk("idle_no_req", 64'(bif.imem_req), 64'(0));
    tick(); @(negedge clk);
    chk("first_req", 64'(bif.imem_req), 64'(1));
    chk("first_addr", 64'(bif.imem_addr), 64'(16'h0000));
    tick(); @(negedge clk); chk("t1_not_valid", 64'(bif.instr_valid), 64'(0));
    tick(); @(negedge clk);
    chk("t2_valid", 64'(bif.instr_valid), 64'(1));
    chk("t2_out", 64'(bif.instr_out), 64'(32'h100));
    tick(); @(negedge clk); chk("t3_out", 64'(bif.instr_out), 64'(32'h101));
    tick(); @(negedge clk); chk("t4_out", 64'(bif.instr_out), 64'(32'h102));
    repeat (4) tick();
    bif.run = 1'b0;
    repeat (10) tick();

    // Decoder stalled: exactly DEPTH grants, then requests stop.
    bif.instr_ready = 1'b0;
    bif.run = 1'b1;
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bif.imem_req && bif.imem_gnt) grants++;
      tick();
    end
    chk("stall_grants", 64'(grants), 64'(DEPTH));
    @(negedge clk); chk("stall_req_low", 64'(bif.imem_req), 64'(0));
    tick(); bif.instr_ready = 1'b1;
    repeat (8) tick();
    bif.run = 1'b0;
    repeat (12) tick();

    // Redirect to 0x40 with two reads in flight (4-cycle memory).
    lat_fix = 4;
    tick(); bif.run = 1'b1;
    tick(); gnt_mode = 0;
    tick(); bif.redirect = 1'b1; bif.redirect_pc = 16'h0040;
    tick(); bif.redirect = 1'b0; gnt_mode = 1;
    @(negedge clk);
    chk("flush_req_low0", 64'(bif.imem_req), 64'(0));
    chk("flush_addr", 64'(bif.imem_addr), 64'(16'h0040));
    chk("flush_valid_low", 64'(bif.instr_valid), 64'(0));
    tick(); @(negedge clk); chk("flush_req_low1", 64'(bif.imem_req), 64'(0));
    tick(); @(negedge clk); chk("flush_req_low2", 64'(bif.imem_req), 64'(0));
    tick(); @(negedge clk);
    chk("redir_req", 64'(bif.imem_req), 64'(1));
    chk("redir_addr", 64'(bif.imem_addr), 64'(16'h0040));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(); @(negedge clk);
      found = bif.instr_valid;
    end
    chk("redir_valid_seen", 64'(found), 64'(1));
    chk("redir_first_pc", 64'(bif.instr_pc), 64'(16'h0040));
    chk("redir_first_out", 64'(bif.instr_out), 64'(32'h140));
    tick(); bif.run = 1'b0;
    repeat (20) tick();
    lat_fix = 1;

    // PC wrap at the top of the address space.
    tick(); bif.redirect = 1'b1; bif.redirect_pc = 16'hFFFF;
    tick(); bif.redirect = 1'b0; bif.run = 1'b1;
    @(negedge clk);
    chk("wrap_idle_req", 64'(bif.imem_req), 64'(0));
    chk("wrap_addr0", 64'(bif.imem_addr), 64'(16'hFFFF));
    tick(); @(negedge clk);
    chk("wrap_req", 64'(bif.imem_req), 64'(1));
    chk("wrap_addr1", 64'(bif.imem_addr), 64'(16'hFFFF));
    tick(); @(negedge clk); chk("wrap_addr2", 64'(bif.imem_addr), 64'(16'h0000));
    repeat (4) tick();
    bif.run = 1'b0;
    repeat (10) tick();

    // Random grants, latency, backpressure and redirects.
    gnt_mode = 2;
    lat_fix = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      bif.run = ($urandom_range(0, 9) != 0);
      bif.instr_ready = ($urandom_range(0, 2) != 0);
      bif.redirect = ($urandom_range(0, 24) == 0);
      bif.redirect_pc = 16'($urandom_range(0, 65535));
    end
    tick();
    bif.run = 1'b0;
    bif.redirect = 1'b0;
    bif.instr_ready = 1'b1;
    gnt_mode = 1;
    repeat (30) tick();
    @(negedge clk);
    chk("end_empty_valid", 64'(bif.instr_valid), 64'(0));
    chk("end_empty_out", 64'(bif.instr_out), 64'(FILL));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
